dram_port_arbiter: RTL

//  Shares the single-port data RAM between the core load/store path (execution stage) and a

---
 rtl/dram_port_arbiter_pkg.sv | 16 +
 rtl/dram_port_arbiter_if.sv | 51 +++++
 rtl/dram_port_arbiter_starve_counter.sv | 20 ++
 rtl/dram_port_arbiter.sv | 79 +++++++
 4 files changed

// File: rtl/dram_port_arbiter_pkg.sv
// Shared encodings for the data-RAM port arbiter: owner of the in-flight read,
// arbiter state and the write-enable value that marks a read.
package dram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_e;

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [3:0] WEN_READ = 4'b0000;

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Core, debug and RAM-side signals of the data-RAM arbiter. The arbiter uses the
// slave view; the surrounding core/debug/RAM logic uses the master view.
interface dram_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            core_req;
  logic [DW/8-1:0] core_wen;
  logic [AW-1:0]   core_addr;
  logic [DW-1:0]   core_wdata;
  logic            core_gnt;
  logic            core_rvalid;
  logic [DW-1:0]   core_rdata;

  logic            dbg_req;
  logic [DW/8-1:0] dbg_wen;
  logic [AW-1:0]   dbg_addr;
  logic [DW-1:0]   dbg_wdata;
  logic            dbg_lock;
  logic            dbg_gnt;
  logic            dbg_rvalid;
  logic [DW-1:0]   dbg_rdata;

  logic            ram_en;
  logic [DW/8-1:0] ram_wen;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW-1:0]   ram_rdata;

  logic            hold_req;

  modport slave (
    input  core_req, core_wen, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  dbg_req, dbg_wen, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output ram_en, ram_wen, ram_addr, ram_wdata,
    input  ram_rdata,
    output hold_req
  );

  modport master (
    output core_req, core_wen, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output dbg_req, dbg_wen, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  ram_en, ram_wen, ram_addr, ram_wdata,
    output ram_rdata,
    input  hold_req
  );
endinterface

// File: rtl/dram_port_arbiter_starve_counter.sv
// Saturating count of consecutive refused debug cycles; at_max lets debug win once.
module arb_starve_counter #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  logic [3:0] cnt;

  assign at_max = (cnt == 4'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr)             cnt <= '0;
    else if (inc && !at_max)  cnt <= cnt + 4'd1;
  end
endmodule

// File: rtl/dram_port_arbiter.sv
// Single-port data RAM shared between core load/store and the debug/loader port:
// core priority, starvation guard and exclusive debug lock; read data returns one cycle later.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  dram_port_arbiter_if.slave bus
);
  logic [0:0] state_q, state_d;
  owner_e     owner_q, owner_d;
  logic       locked, at_max, core_gnt, dbg_gnt;
  logic       core_rd, dbg_rd;

  // A LOCKED cycle with dbg_lock already dropped arbitrates as ARB.
  assign locked   = (state_q == ST_LOCKED) && bus.dbg_lock;
  assign dbg_gnt  = rst_n && bus.dbg_req && (locked || !bus.core_req || at_max);
  assign core_gnt = rst_n && bus.core_req && !locked && !dbg_gnt;
  assign state_d  = (locked || (dbg_gnt && bus.dbg_lock)) ? ST_LOCKED : ST_ARB;

  assign bus.core_gnt = core_gnt;
  assign bus.dbg_gnt  = dbg_gnt;
  assign bus.hold_req = rst_n && bus.core_req && !core_gnt;

  arb_starve_counter #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (bus.dbg_req && !dbg_gnt),
    .clr    (dbg_gnt || !bus.dbg_req),
    .at_max (at_max)
  );

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_wen   = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (core_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_wen   = bus.core_wen;
      bus.ram_addr  = {bus.core_addr[AW-1:2], 2'b00};
      bus.ram_wdata = bus.core_wdata;
    end else if (dbg_gnt) begin
      bus.ram_en    = 1'b1;
      bus.ram_wen   = bus.dbg_wen;
      bus.ram_addr  = {bus.dbg_addr[AW-1:2], 2'b00};
      bus.ram_wdata = bus.dbg_wdata;
    end
  end

  assign core_rd = core_gnt && (bus.core_wen == WEN_READ);
  assign dbg_rd  = dbg_gnt && (bus.dbg_wen == WEN_READ);

  always_comb begin
    owner_d = OWN_NONE;
    if (core_rd)     owner_d = OWN_CORE;
    else if (dbg_rd) owner_d = OWN_DBG;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      owner_q <= OWN_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // owner_q marks the cycle in which the RAM presents data for last cycle's read.
  assign bus.core_rvalid = (owner_q == OWN_CORE);
  assign bus.dbg_rvalid  = (owner_q == OWN_DBG);
  assign bus.core_rdata  = bus.core_rvalid ? bus.ram_rdata : '0;
  assign bus.dbg_rdata   = bus.dbg_rvalid  ? bus.ram_rdata : '0;
endmodule
